// File: rtl/hilo_pkg.sv
// Shared encodings, FSM states and default latencies for the HI/LO register block.
package hilo_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] DIV_LAT  = 6'd34;
  localparam logic [CNT_W-1:0] MULT_LAT = 6'd34;
  localparam logic [CNT_W-1:0] DZ_LAT   = 6'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DIV  = 2'd1,
    WAIT_MULT = 2'd2,
    DZ_CLR    = 2'd3
  } state_t;

endpackage

// File: rtl/hilo_lat_counter.sv
// Loadable latency counter: load starts at 1, run increments, otherwise parks at 0.
// Compare outputs flag the divide-by-zero sample point, end of the clear window, and unit latency.
module hilo_lat_counter
  import hilo_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] lat,
  output logic [CNT_W-1:0] cnt,
  output logic             at_dz,
  output logic             at_dz_end,
  output logic             at_lat
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (load)
      cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (run)
      cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign cnt       = cnt_reg;
  assign at_dz     = (cnt_reg == DZ_LAT);
  // Clear window spans two cycles after the divide-by-zero sample point.
  assign at_dz_end = (cnt_reg == (DZ_LAT + 6'd2));
  assign at_lat    = (cnt_reg == lat);

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers: launches MULT/DIV, waits the fixed unit latency,
// commits the result, and services MTHI/MTLO writes.
module hilo_unit
  import hilo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        op_start,
  input  logic [1:0]  op_sel,
  input  logic [31:0] wdata,
  output logic        div_start,
  output logic        div_clear,
  output logic        mult_start,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div0,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0_exc
);

  state_t      state_reg, state_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        div_start_reg, div_start_next;
  logic        mult_start_reg, mult_start_next;
  logic        div_clear_reg, div_clear_next;
  logic        done_reg, done_next;
  logic        div0_exc_reg, div0_exc_next;

  logic             cnt_load;
  logic             cnt_run;
  logic [CNT_W-1:0] cnt_lat;
  logic [CNT_W-1:0] cnt;
  logic             at_dz;
  logic             at_dz_end;
  logic             at_lat;

  assign cnt_run = (state_reg != IDLE);
  assign cnt_lat = (state_reg == WAIT_MULT) ? MULT_LAT : DIV_LAT;

  hilo_lat_counter u_cnt (
    .clock     (clock),
    .reset     (reset),
    .load      (cnt_load),
    .run       (cnt_run),
    .lat       (cnt_lat),
    .cnt       (cnt),
    .at_dz     (at_dz),
    .at_dz_end (at_dz_end),
    .at_lat    (at_lat)
  );

  always_comb begin
    state_next      = state_reg;
    hi_next         = hi_reg;
    lo_next         = lo_reg;
    div_start_next  = 1'b0;
    mult_start_next = 1'b0;
    div_clear_next  = 1'b0;
    done_next       = 1'b0;
    div0_exc_next   = 1'b0;
    cnt_load        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (op_start) begin
          unique case (op_sel)
            OP_MTHI: hi_next = wdata;
            OP_MTLO: lo_next = wdata;
            OP_DIV: begin
              div_start_next = 1'b1;
              cnt_load       = 1'b1;
              state_next     = WAIT_DIV;
            end
            default: begin
              mult_start_next = 1'b1;
              cnt_load        = 1'b1;
              state_next      = WAIT_MULT;
            end
          endcase
        end
      end
      WAIT_DIV: begin
        if (at_dz && div0) begin
          div0_exc_next  = 1'b1;
          div_clear_next = 1'b1;
          state_next     = DZ_CLR;
        end else if (at_lat) begin
          hi_next    = div_hi;
          lo_next    = div_lo;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_MULT: begin
        if (at_lat) begin
          hi_next    = mult_hi;
          lo_next    = mult_lo;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        // DZ_CLR: keep the divider clear asserted one extra cycle, then release.
        if (at_dz_end)
          state_next = IDLE;
        else
          div_clear_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      hi_reg         <= '0;
      lo_reg         <= '0;
      div_start_reg  <= 1'b0;
      mult_start_reg <= 1'b0;
      div_clear_reg  <= 1'b0;
      done_reg       <= 1'b0;
      div0_exc_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hi_reg         <= hi_next;
      lo_reg         <= lo_next;
      div_start_reg  <= div_start_next;
      mult_start_reg <= mult_start_next;
      div_clear_reg  <= div_clear_next;
      done_reg       <= done_next;
      div0_exc_reg   <= div0_exc_next;
    end
  end

  assign hi         = hi_reg;
  assign lo         = lo_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign div0_exc   = div0_exc_reg;
  assign div_start  = div_start_reg;
  assign mult_start = mult_start_reg;
  assign div_clear  = div_clear_reg;

endmodule
